// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//
// Parallel-in, serial-out framed transmitter. A load request in IDLE captures
// one data word. The word then leaves on a single line as a frame:
//   start bit (0), data bits LSB first, optional even-parity bit, stop bit (1).
// Every bit is held for CLKS_PER_BIT clock cycles. frameDone pulses for one
// cycle when the stop bit ends, and the block returns to IDLE at that point.
//
// Handshake: load is a request qualified by ready. A rising clk edge with
// ready = 1 and load = 1 starts a frame. While ready = 0, load is ignored:
// nothing is queued and the frame in flight is not affected.
//
// Parameters:
//   DATA_WIDTH    data bits per frame (1..16)
//   CLKS_PER_BIT  clk cycles per serial bit (>= 1)
//   PARITY_EN     1 = append an even-parity bit after the data bits
//
// Ports:
//   clk        in   system clock, rising edge
//   asyncReset in   asynchronous, active-high reset
//   D          in   parallel word, captured on the load edge
//   load       in   transmit request
//   ready      out  1 = idle and accepting load
//   txOut      out  serial line, idles high (mark)
//   notTxOut   out  complement of txOut
//   frameDone  out  one-cycle pulse at the end of the stop bit
//   stateDbg   out  current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module serial_frame_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                  clk,
    input  logic                  asyncReset,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  load,
    output logic                  ready,
    output logic                  txOut,
    output logic                  notTxOut,
    output logic                  frameDone,
    output logic [2:0]            stateDbg
);

    // Counter widths stay at least one bit wide, so CLKS_PER_BIT = 1 and
    // DATA_WIDTH = 1 still give legal vectors. With CLKS_PER_BIT = 1 the
    // cycle counter stays at 0 and every cycle is a wrap.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_q,   bit_d;
    logic [CW-1:0]         cnt_q,   cnt_d;
    logic                  par_q,   par_d;
    logic                  done_q,  done_d;

    // The current bit ends on the edge where the cycle counter wraps.
    logic bit_end;
    assign bit_end = (cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge asyncReset) begin
        if (asyncReset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        done_d  = 1'b0;

        // The cycle counter is idle at 0 and runs freely while a frame is out.
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    shift_d = D;
                    bit_d   = '0;
                    par_d   = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    // The parity bit builds up from each data bit as it
                    // leaves, so it is ready by the time the data bits end.
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state only. They do not depend
    // combinationally on load or D, and reset forces them straight to mark.
    // -------------------------------------------------------------------------
    logic tx_line;

    always_comb begin
        tx_line = 1'b1;
        case (state_q)
            S_IDLE:   tx_line = 1'b1;
            S_START:  tx_line = 1'b0;
            S_DATA:   tx_line = shift_q[0];
            S_PARITY: tx_line = par_q;
            S_STOP:   tx_line = 1'b1;
            default:  tx_line = 1'b1;
        endcase
    end

    assign txOut     = tx_line;
    assign notTxOut  = ~tx_line;
    assign ready     = (state_q == S_IDLE);
    assign frameDone = done_q;
    assign stateDbg  = state_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Bench for serial_frame_tx with default parameters (8 data bits, 4 clocks per
// bit, even parity). The reference holds a queue of the line level for every
// cycle of the frame in flight. That queue is built straight from the frame
// rules: start, data LSB first, parity, stop, each bit repeated CLKS_PER_BIT
// times. An empty queue means idle. frameDone is expected in the first idle
// cycle after a frame. Literal bit patterns and cycle counts pin the frame
// shape independently of that queue.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int PEN = 1;

    // ------------------------------------------------------------------ clock/reset
    logic          clk        = 1'b0;
    logic          asyncReset = 1'b1;
    logic          load       = 1'b0;
    logic [DW-1:0] D          = '0;
    logic          ready;
    logic          txOut;
    logic          notTxOut;
    logic          frameDone;
    logic [2:0]    stateDbg;

    always #5 clk = ~clk;

    serial_frame_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .PARITY_EN   (PEN)
    ) dut (
        .clk       (clk),
        .asyncReset(asyncReset),
        .D         (D),
        .load      (load),
        .ready     (ready),
        .txOut     (txOut),
        .notTxOut  (notTxOut),
        .frameDone (frameDone),
        .stateDbg  (stateDbg)
    );

    // ------------------------------------------------------------------ bookkeeping
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;
    int done_cyc[$];

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ reference model
    logic exp_q[$];
    logic done_exp = 1'b0;

    function automatic void push_frame(input logic [DW-1:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (PEN != 0) bits.push_back(^d);
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int c = 0; c < CPB; c++) exp_q.push_back(bits[i]);
        end
    endfunction

    initial forever begin
        @(posedge clk or posedge asyncReset);
        if (asyncReset) begin
            exp_q.delete();
            done_exp = 1'b0;
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            done_exp = (exp_q.size() == 0);
        end else begin
            done_exp = 1'b0;
            if (load) push_frame(D);
        end
    end

    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------ per-cycle compare
    always @(negedge clk) begin
        logic e_tx;
        e_tx = (exp_q.size() == 0) ? 1'b1 : exp_q[0];
        check1("txOut", txOut, e_tx);
        check1("notTxOut", notTxOut, !e_tx);
        check1("ready", ready, exp_q.size() == 0);
        check1("frameDone", frameDone, done_exp);
        if (frameDone === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
    end

    // ------------------------------------------------------------------ driver tasks
    // Sends one frame and checks the middle of every bit against a literal
    // pattern (index 0 = start bit, 10 = stop bit). With poke set, a second
    // load with a different word is pulsed during the data bits and D keeps
    // changing; neither may disturb the frame.
    task automatic literal_frame(input logic [DW-1:0] d, input logic [10:0] bits, input bit poke);
        int low;
        int d0;
        low = 0;
        @(negedge clk);
        D    = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        d0   = done_cnt;
        for (int k = 0; k < 11; k++) begin
            for (int c = 0; c < CPB; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                if (ready === 1'b0) low++;
                if (c == 1) check1($sformatf("bit%0d_of_%h", k, d), txOut, bits[k]);
                if (poke && k == 5 && c == 0) begin
                    D    = 8'h3C;
                    load = 1'b1;
                end
                if (poke && k == 5 && c == 1) load = 1'b0;
                if (poke && k >= 6) D = DW'($urandom);
            end
        end
        @(negedge clk);
        check1("ready_after_frame", ready, 1'b1);
        check1("done_at_frame_end", frameDone, 1'b1);
        check_int("ready_low_cycles", low, 44);
        repeat (8) @(negedge clk);
        check_int("done_pulses_per_frame", done_cnt - d0, 1);
        check1("no_second_frame", ready, 1'b1);
    endtask

    // ------------------------------------------------------------------ stimulus
    initial begin
        int d0;

        // Reset held from time 0: idle values before any clock edge.
        #3;
        check1("rst_txOut", txOut, 1'b1);
        check1("rst_notTxOut", notTxOut, 1'b0);
        check1("rst_ready", ready, 1'b1);
        check1("rst_frameDone", frameDone, 1'b0);
        repeat (3) @(negedge clk);
        asyncReset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset asserted between edges.
        #2 asyncReset = 1'b1;
        #1;
        check1("mid_rst_txOut", txOut, 1'b1);
        check1("mid_rst_notTxOut", notTxOut, 1'b0);
        check1("mid_rst_ready", ready, 1'b1);
        check1("mid_rst_frameDone", frameDone, 1'b0);
        #1 asyncReset = 1'b0;

        // Directed frames.
        literal_frame(8'hA5, 11'b10101001010, 1'b0);
        literal_frame(8'h01, 11'b11000000010, 1'b0);
        literal_frame(8'h00, 11'b10000000000, 1'b0);
        literal_frame(8'hA5, 11'b10101001010, 1'b1);

        // load held high: back-to-back frames with one idle cycle each.
        @(negedge clk);
        D    = 8'hF0;
        load = 1'b1;
        d0   = done_cyc.size();
        repeat (140) @(negedge clk);
        check_int("held_load_frames", done_cyc.size() - d0, 3);
        for (int i = d0 + 1; i < done_cyc.size(); i++)
            check_int("held_load_spacing", done_cyc[i] - done_cyc[i-1], 45);
        load = 1'b0;
        repeat (50) @(negedge clk);

        // Reset during data bit 3 of an A5 frame.
        @(negedge clk);
        D    = 8'hA5;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4 + 3 * CPB + 1) @(negedge clk);
        check1("abort_point_bit3", txOut, 1'b0);
        d0 = done_cnt;
        #2 asyncReset = 1'b1;
        #1;
        check1("abort_txOut", txOut, 1'b1);
        check1("abort_ready", ready, 1'b1);
        check1("abort_frameDone", frameDone, 1'b0);
        #1 asyncReset = 1'b0;
        repeat (50) @(negedge clk);
        check_int("abort_no_done", done_cnt - d0, 0);
        literal_frame(8'h5A, 11'b10010110100, 1'b0);

        // Randomized traffic: random load requests and words every cycle,
        // with an occasional reset between edges.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            load = ($urandom_range(0, 3) == 0);
            D    = DW'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 asyncReset = 1'b1;
                #1 asyncReset = 1'b0;
            end
        end
        load = 1'b0;
        repeat (60) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
